siren_generator: RTL and testbench
==================================

# siren_generator

Parametrised multi-mode alarm sounder driving a single piezo/speaker pin. It supports steady tone, two-tone, triangle sweep and pulsed-beep patterns, and its pitch limits, sweep rate and beep cadence are set at elaboration time. It sits between the alarm control FSM (which drives `enable` and `mode`) and the board buzzer pin. When silent, the output rests at a defined idle level.

## Interface
- `DIV_W`, 16: width of the half-period divider and of the tone counter.
- `DIV_MIN`, 8192: half-period in clocks for the high tone, which is also the top of the sweep.
- `DIV_MAX`, 16320: half-period in clocks for the low tone, which is also the bottom of the sweep.
- `STEP`, 64: change in divider value per sweep step.
- `STEP_TICKS`, 32768: clocks between sweep steps.
- `BEEP_TICKS`, 4194304: clocks per two-tone half-cycle and per beep on/off phase.
- `MUTE_TICKS`, 2^28-1: auto-mute timeout in clocks. Used only with `SIREN_AUTO_MUTE_EN`.
- `IDLE_LEVEL`, 1: speaker level whenever the block is silent.
- Constraints: 2 ≤ `DIV_MIN` ≤ `DIV_MAX` < 2^`DIV_W`; `STEP` ≥ 1.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `enable` input, 1 bit: sound request, level-sensitive.
- `mode` input, 2 bits: pattern select. 00 steady, 01 two-tone, 10 sweep, 11 pulsed.
- `speaker` output, 1 bit: square-wave drive.
- `active` output, 1 bit: high while the block is enabled and not muted.
- `muted` output, 1 bit: high while the auto-mute is asserted.

## Operation
- **Tone core**
  - Down-counter `tcnt` runs with a current divider `cur_div`.
  - When `tcnt`==0: toggle `speaker` and reload `tcnt` with `cur_div`-1.
  - Result: square-wave period is 2·`cur_div` clocks.
  - A change to `cur_div` takes effect only at the next reload. No runt pulses.
- **Silence**
  - The block is silent when `enable`=0, when in the pulsed off-phase, or when muted.
  - While silent: `speaker`=`IDLE_LEVEL` and `tcnt` is held at `cur_div`-1.
- **Mode 00 (steady):** `cur_div`=`DIV_MIN`.
- **Mode 01 (two-tone)**
  - `cur_div` alternates between `DIV_MIN` and `DIV_MAX` every `BEEP_TICKS` clocks.
  - It starts on `DIV_MIN`.
  - No phase reset at the swap.
- **Mode 10 (sweep)**
  - `cur_div` starts at `DIV_MAX`, with direction down (pitch rising).
  - Every `STEP_TICKS` clocks it moves by `STEP`.
  - If the next value would pass `DIV_MIN` or `DIV_MAX`, it clamps to that limit and reverses direction.
  - The limit value is held for one full step before the divider moves back.
- **Mode 11 (pulsed)**
  - Tone at `DIV_MIN` for `BEEP_TICKS`, then silent for `BEEP_TICKS`, repeating.
  - Starts in the tone phase.
  - At each tone-phase start, `tcnt` restarts from `cur_div`-1.
- **Pattern restart**
  - `mode` is registered every cycle.
  - A restart happens when `enable` rises, or when the registered `mode` differs from the incoming `mode` while enabled.
  - On restart: the pattern timer clears, the sweep returns to `DIV_MAX` going down, the two-tone and pulsed phases return to their first phase, `tcnt` reloads, and `speaker` is forced to `IDLE_LEVEL`.
- **Width rules**
  - Pattern timers are `$clog2(max(STEP_TICKS, BEEP_TICKS))` bits wide.
  - Sweep arithmetic is done in `DIV_W`+1 bits so the clamp cannot wrap.
  - The mute timer saturates.
- **Priority:** `rst` > `enable`=0 > mute > pattern.

## Timing
- **Reset:** on any `rst`=1 edge: `speaker`=`IDLE_LEVEL`, `active`=0, `muted`=0, all counters 0, `cur_div`=`DIV_MAX`, sweep direction down. Reset applied mid-tone takes effect at that edge.
- **Enable rising:** `enable` sampled high at edge N gives `active`=1 after edge N. The first `speaker` toggle (to ~`IDLE_LEVEL`) happens at edge N+`cur_div`.
- **Enable falling:** `enable`=0 sampled at edge N gives `speaker`=`IDLE_LEVEL` and `active`=0 after edge N. There is no tail.
- **Timer events:** sweep steps, two-tone swaps and pulsed phase changes occur every exactly `STEP_TICKS` or `BEEP_TICKS` clocks after the restart edge.
- **Simultaneous step and reload:** if a step and a reload land on the same edge, the reload uses the old `cur_div`.

## Configuration
- Macro: `SIREN_AUTO_MUTE_EN`.
- **When defined**
  - A saturating counter counts consecutive cycles with `enable`=1.
  - On reaching `MUTE_TICKS`: `muted`=1, `active`=0, and `speaker`=`IDLE_LEVEL` from the next edge.
  - Mute clears only when `enable`=0 is sampled for at least 1 cycle. The counter then resets.
  - A mode change does not reset the counter.
- **When undefined:** `muted` is tied 0, there is no counter, and `MUTE_TICKS` is ignored.

## Test plan
Parameters for all scenarios: `DIV_MIN`=4, `DIV_MAX`=12, `STEP`=4, `STEP_TICKS`=50, `BEEP_TICKS`=40, `MUTE_TICKS`=200, `IDLE_LEVEL`=1.

1. **Reset.** `rst`=1 for 3 cycles with `enable`=1 and `mode`=00 → `speaker`=1 and `active`=0 throughout. After release, the first toggle comes 4 cycles after the first enabled edge.
2. **Steady mode.** `mode`=00, `enable` held → `speaker` toggles every 4 clocks (period 8). `enable` drops mid-high-phase → `speaker`=1 and `active`=0 the next edge.
3. **Sweep mode.** `mode`=10 → half-period sequence 12, 8, 4, 4, 8, 12, 12, 8, with each value lasting 50 clocks. No pulse shorter than the outgoing divider.
4. **Pulsed mode.** `mode`=11 → 40 clocks toggling at half-period 4, then 40 clocks fixed at 1, repeating.
5. **Mode change.** Switch from 00 to 01 mid-tone → `speaker` forced to 1 and the pattern restarts. Half-period is 4 for 40 clocks, then 12 for 40 clocks.
6. **Auto-mute.** With `SIREN_AUTO_MUTE_EN`: `enable` held 200 cycles → `muted`=1, `speaker`=1. `enable` low 1 cycle then high → tone resumes and `muted`=0. Without the macro, `muted`=0 forever and the tone never stops.

Source files
------------

// File: rtl/siren_generator.sv
// siren_generator: multi-mode alarm sounder (steady, two-tone, sweep, pulsed); optional auto-mute via SIREN_AUTO_MUTE_EN
module siren_generator #(
  parameter int DIV_W      = 16,
  parameter int DIV_MIN    = 8192,
  parameter int DIV_MAX    = 16320,
  parameter int STEP       = 64,
  parameter int STEP_TICKS = 32768,
  parameter int BEEP_TICKS = 4194304,
  parameter int MUTE_TICKS = 2**28 - 1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic       speaker,
  output logic       active,
  output logic       muted
);
  localparam int TMAX = STEP_TICKS > BEEP_TICKS ? STEP_TICKS : BEEP_TICKS;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [DIV_W-1:0] DMIN = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DMAX = DIV_W'(DIV_MAX);
  localparam logic [DIV_W:0] STEP_W = (DIV_W + 1)'(STEP);
  localparam logic [TW-1:0] STEP_END = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] BEEP_END = TW'(BEEP_TICKS - 1);

  if (DIV_MIN < 2 || DIV_MIN > DIV_MAX || DIV_MAX >= 2**DIV_W || STEP < 1 || MUTE_TICKS < 1) begin : g_bad_params
    $error("siren_generator: illegal parameter set");
  end

  logic [1:0] mode_q;
  logic en_q, phase, up;
  logic [TW-1:0] ptimer, timer_n;
  logic [DIV_W-1:0] cur_div, div_n, tcnt;
  logic [DIV_W:0] sum, diff;
  logic restart, evt, hi, lo, phase_n, up_n, tstart, silent, mute_n;

  // next pattern state: restart, timer events, two-tone swap and clamped sweep
  always_comb begin
    restart = enable && (!en_q || mode_q != mode);
    evt = ptimer == (mode == 2'b10 ? STEP_END : BEEP_END);
    sum = {1'b0, cur_div} + STEP_W;
    diff = {1'b0, cur_div} - STEP_W;
    hi = sum > {1'b0, DMAX};
    lo = diff[DIV_W] || diff < {1'b0, DMIN};
    timer_n = ptimer;
    phase_n = phase;
    up_n = up;
    div_n = cur_div;
    if (restart) begin
      timer_n = '0;
      phase_n = 1'b0;
      up_n = 1'b0;
      div_n = mode == 2'b10 ? DMAX : DMIN;
    end else if (enable) begin
      timer_n = evt ? '0 : ptimer + TW'(1);
      if (evt) begin
        phase_n = !phase;
        if (mode == 2'b01) div_n = phase ? DMIN : DMAX;
        if (mode == 2'b10) begin
          div_n = up ? (hi ? DMAX : sum[DIV_W-1:0]) : (lo ? DMIN : diff[DIV_W-1:0]);
          up_n = up ? !hi : lo;
        end
      end
    end
    tstart = enable && !restart && evt && mode == 2'b11 && phase;
    silent = !enable || mute_n || (mode == 2'b11 && phase_n);
  end

`ifdef SIREN_AUTO_MUTE_EN
  localparam int MW = $clog2(MUTE_TICKS + 1);
  logic [MW-1:0] mcnt;
  assign mute_n = enable && mcnt >= MW'(MUTE_TICKS - 1);
  // consecutive-enable counter saturating at the timeout; any low enable clears it
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      mcnt <= '0;
      muted <= 1'b0;
    end else begin
      if (mcnt != MW'(MUTE_TICKS)) mcnt <= mcnt + MW'(1);
      muted <= mute_n;
    end
  end
`else
  assign mute_n = 1'b0;
  assign muted = 1'b0;
`endif

  // pattern registers and tone core; reloads use the divider in force before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 2'b00;
      en_q <= 1'b0;
      ptimer <= '0;
      phase <= 1'b0;
      up <= 1'b0;
      cur_div <= DMAX;
      tcnt <= '0;
      speaker <= IDLE_LEVEL;
      active <= 1'b0;
    end else begin
      mode_q <= mode;
      en_q <= enable;
      ptimer <= timer_n;
      phase <= phase_n;
      up <= up_n;
      cur_div <= div_n;
      active <= enable && !mute_n;
      if (silent || restart || tstart) begin
        tcnt <= div_n - DIV_W'(1);
        speaker <= IDLE_LEVEL;
      end else if (tcnt == '0) begin
        tcnt <= cur_div - DIV_W'(1);
        speaker <= !speaker;
      end else begin
        tcnt <= tcnt - DIV_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_siren_generator.sv
// tb_siren_generator: table, directed and random checks of siren_generator against a time-based model
module tb_siren_generator;
  localparam int DMIN = 4, DMAX = 12, STP = 4, ST = 50, BT = 40, MT = 200;
`ifdef SIREN_AUTO_MUTE_EN
  localparam bit MUTE_ON = 1'b1;
`else
  localparam bit MUTE_ON = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic speaker, active, muted;
  int vectors = 0, miscompares = 0, shown = 0;

  siren_generator #(
    .DIV_W(16), .DIV_MIN(DMIN), .DIV_MAX(DMAX), .STEP(STP),
    .STEP_TICKS(ST), .BEEP_TICKS(BT), .MUTE_TICKS(MT), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .speaker(speaker), .active(active), .muted(muted)
  );

  always #5 clk = ~clk;

  // model: time t in edges since the last restart, toggle times scheduled from the divider timeline
  int t, nxt, mcnt;
  bit m_spk, m_act, m_mut, p_en;
  logic [1:0] p_mode;
  int sweep_seq [6] = '{12, 8, 4, 4, 8, 12};

  function automatic int div_at(input logic [1:0] md, input int tt);
    return md == 2'd2 ? sweep_seq[(tt / ST) % 6] : (md == 2'd1 && (tt / BT) % 2 == 1) ? DMAX : DMIN;
  endfunction

  task automatic model(input bit r, input bit e, input logic [1:0] md);
    bit rs, sil;
    if (r) begin
      m_spk = 1'b1; m_act = 1'b0; m_mut = 1'b0; mcnt = 0; p_en = 1'b0; p_mode = 2'b00;
      return;
    end
    rs = e && (!p_en || p_mode != md);
    if (MUTE_ON) begin
      mcnt = e ? (mcnt < MT ? mcnt + 1 : mcnt) : 0;
      m_mut = e && mcnt >= MT;
    end
    if (rs) begin
      t = 0;
      nxt = div_at(md, 0);
    end else if (e) t++;
    sil = !e || m_mut || (md == 2'd3 && (t / BT) % 2 == 1);
    m_act = e && !m_mut;
    if (sil || rs) m_spk = 1'b1;
    else if (md == 2'd3 && t % (2 * BT) == 0) begin
      nxt = t + DMIN;
      m_spk = 1'b1;
    end else if (t == nxt) begin
      m_spk = !m_spk;
      nxt = t + div_at(md, t - 1);
    end
    p_en = e;
    p_mode = md;
  endtask

  task automatic chk(input string nm, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (shown < 30) $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
      shown++;
    end
  endtask

  task automatic drive(input bit r, input bit e, input logic [1:0] md);
    rst = r;
    enable = e;
    mode = md;
    @(posedge clk);
    model(r, e, md);
    #1;
  endtask

  task automatic step_chk(input bit r, input bit e, input logic [1:0] md);
    drive(r, e, md);
    chk("speaker", speaker, m_spk);
    chk("active", active, m_act);
    chk("muted", muted, m_mut);
  endtask

  typedef struct packed {
    logic r;
    logic e;
    logic [1:0] md;
    logic spk;
    logic act;
  } vec_t;
  vec_t tbl [22];

  initial begin
    bit r, e;
    logic [1:0] md;
    // reset with enable high, steady tone, enable drop in high and low phases, reset mid-tone
    tbl = '{
      6'b1_1_00_1_0, 6'b1_1_00_1_0, 6'b1_1_00_1_0,
      6'b0_1_00_1_1, 6'b0_1_00_1_1, 6'b0_1_00_1_1, 6'b0_1_00_1_1,
      6'b0_1_00_0_1, 6'b0_1_00_0_1, 6'b0_1_00_0_1, 6'b0_1_00_0_1,
      6'b0_1_00_1_1, 6'b0_1_00_1_1,
      6'b0_0_00_1_0,
      6'b0_1_00_1_1, 6'b0_1_00_1_1, 6'b0_1_00_1_1, 6'b0_1_00_1_1,
      6'b0_1_00_0_1, 6'b0_1_00_0_1,
      6'b0_0_00_1_0,
      6'b1_1_00_1_0
    };
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].md);
      chk("tbl_speaker", speaker, tbl[i].spk);
      chk("tbl_active", active, tbl[i].act);
      chk("tbl_muted", muted, 1'b0);
    end

    // sweep through two full triangle periods
    step_chk(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 650; i++) step_chk(1'b0, 1'b1, 2'd2);

    // pulsed beeps
    step_chk(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 250; i++) step_chk(1'b0, 1'b1, 2'd3);

    // steady into two-tone while the speaker is low
    for (int i = 0; i < 6; i++) step_chk(1'b0, 1'b1, 2'd0);
    chk("pre_switch_low", speaker, 1'b0);
    step_chk(1'b0, 1'b1, 2'd1);
    chk("mode_change_idle", speaker, 1'b1);
    for (int i = 0; i < 200; i++) step_chk(1'b0, 1'b1, 2'd1);

    // long enable for the auto-mute, one low cycle, resume
    step_chk(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 260; i++) begin
      step_chk(1'b0, 1'b1, 2'd0);
      if (i == 199) chk("mute_flag", muted, MUTE_ON);
      if (i == 120) step_chk(1'b0, 1'b1, 2'd0);
    end
    step_chk(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 30; i++) step_chk(1'b0, 1'b1, 2'd0);
    chk("unmuted", muted, 1'b0);

    // random enable/mode/reset activity
    e = 1'b1;
    md = 2'd0;
    for (int i = 0; i < 20000; i++) begin
      r = $urandom_range(0, 999) == 0;
      if ($urandom_range(0, 199) == 0) e = !e;
      if ($urandom_range(0, 299) == 0) md = 2'($urandom_range(0, 3));
      step_chk(r, e, md);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
